reg_slave: RTL and testbench

REG_SLAVE -- requirements
Module: reg_slave

---
 rtl/reg_slave_pkg.sv | 30 +++
 rtl/reg_slave_irq.sv | 58 +++++
 rtl/reg_slave.sv | 148 ++++++++++++++
 tb/tb_reg_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_slave_pkg.sv
// reg_slave_pkg
// Shared constants for the register slave: bus widths, the register offset
// map, the default ID/unmapped-read values and the address-mapping helper.
// No ports; imported by reg_slave and reg_slave_irq.
package reg_slave_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int IRQ_W    = 8;
  // Byte offset bits that select a register inside the mapped window
  localparam int OFFSET_W = 5;

  localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT   = 32'h4550_0001;
  localparam logic [DATA_W-1:0] UNMAP_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [OFFSET_W-1:0] OFF_ID        = 5'h00;
  localparam logic [OFFSET_W-1:0] OFF_SCRATCH   = 5'h04;
  localparam logic [OFFSET_W-1:0] OFF_CTRL      = 5'h08;
  localparam logic [OFFSET_W-1:0] OFF_STATUS    = 5'h0C;
  localparam logic [OFFSET_W-1:0] OFF_IRQ_STAT  = 5'h10;
  localparam logic [OFFSET_W-1:0] OFF_IRQ_MASK  = 5'h14;
  localparam logic [OFFSET_W-1:0] OFF_TIMESTAMP = 5'h18;
  localparam logic [OFFSET_W-1:0] OFF_ERR_CNT   = 5'h1C;

  // Mapped only inside the 32-byte window and only on word-aligned addresses
  function automatic logic addr_is_mapped(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:OFFSET_W] == '0) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/reg_slave_irq.sv
// reg_slave_irq
// Interrupt status/mask registers and the registered interrupt output.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   irq_src      level interrupt sources, sets IRQ_STAT bits every cycle
//   stat_clr     write-one-to-clear strobe for IRQ_STAT (uses wdata)
//   mask_wr      write strobe for IRQ_MASK (uses wdata)
//   wdata        write data bits from the register pipeline
//   irq_stat     current IRQ_STAT contents
//   irq_mask     current IRQ_MASK contents
//   irq          registered OR of (IRQ_STAT & IRQ_MASK)
module reg_slave_irq
  import reg_slave_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] irq_src,
  input  logic             stat_clr,
  input  logic             mask_wr,
  input  logic [IRQ_W-1:0] wdata,
  output logic [IRQ_W-1:0] irq_stat,
  output logic [IRQ_W-1:0] irq_mask,
  output logic             irq
);

  logic [IRQ_W-1:0] irq_stat_q, irq_stat_d;
  logic [IRQ_W-1:0] irq_mask_q, irq_mask_d;
  logic             irq_q, irq_d;

  // Clear is applied first and the set is ORed in afterwards, so a source
  // that is active in the same cycle as a clear keeps its bit set.
  always_comb begin
    irq_stat_d = irq_stat_q;
    if (stat_clr) begin
      irq_stat_d = irq_stat_d & ~wdata;
    end
    irq_stat_d = irq_stat_d | irq_src;
    irq_mask_d = mask_wr ? wdata : irq_mask_q;
    irq_d      = |(irq_stat_q & irq_mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_stat_q <= irq_stat_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_stat = irq_stat_q;
  assign irq_mask = irq_mask_q;
  assign irq      = irq_q;

endmodule

// File: rtl/reg_slave.sv
// reg_slave
// Two-stage pipelined register slave. A request is captured into stage 1,
// decoded/committed in the next cycle, and acknowledged the cycle after.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   reg_req      one-cycle access strobe (back-to-back allowed)
//   reg_whrl     1 = write, 0 = read
//   reg_addr     byte address
//   reg_wdata    write data
//   reg_ack      one-cycle completion strobe, two cycles after reg_req
//   reg_rdata    read data (0 for writes), valid with reg_ack
//   ctrl_out     CTRL register contents
//   status_in    external status, returned by STATUS reads
//   irq_src      level interrupt sources
//   irq          registered interrupt output
module reg_slave
  import reg_slave_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE   = ID_VALUE_DEFAULT,
  parameter logic [DATA_W-1:0] UNMAP_DATA = UNMAP_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_req,
  input  logic              reg_whrl,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic              reg_ack,
  output logic [DATA_W-1:0] reg_rdata,
  output logic [DATA_W-1:0] ctrl_out,
  input  logic [DATA_W-1:0] status_in,
  input  logic [IRQ_W-1:0]  irq_src,
  output logic              irq
);

  // Stage 1: captured request
  logic              s1_valid_q, s1_valid_d;
  logic              s1_write_q, s1_write_d;
  logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
  logic [DATA_W-1:0] s1_wdata_q, s1_wdata_d;

  // Stage 2: response
  logic              ack_q,   ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Register file
  logic [DATA_W-1:0] scratch_q,   scratch_d;
  logic [DATA_W-1:0] ctrl_q,      ctrl_d;
  logic [DATA_W-1:0] timestamp_q, timestamp_d;
  logic [DATA_W-1:0] err_cnt_q,   err_cnt_d;

  logic                mapped;
  logic                wr_en;
  logic [OFFSET_W-1:0] offset;
  logic                irq_stat_clr;
  logic                irq_mask_wr;
  logic [DATA_W-1:0]   read_val;
  logic [IRQ_W-1:0]    irq_stat;
  logic [IRQ_W-1:0]    irq_mask;

  // Request capture; payload only moves when a request is present
  always_comb begin
    s1_valid_d = reg_req;
    s1_write_d = reg_req ? reg_whrl  : s1_write_q;
    s1_addr_d  = reg_req ? reg_addr  : s1_addr_q;
    s1_wdata_d = reg_req ? reg_wdata : s1_wdata_q;
  end

  // Decode cycle: write enables, register next values and read mux
  always_comb begin
    mapped       = addr_is_mapped(s1_addr_q);
    offset       = s1_addr_q[OFFSET_W-1:0];
    wr_en        = s1_valid_q && s1_write_q && mapped;
    irq_stat_clr = wr_en && (offset == OFF_IRQ_STAT);
    irq_mask_wr  = wr_en && (offset == OFF_IRQ_MASK);

    scratch_d   = (wr_en && (offset == OFF_SCRATCH)) ? s1_wdata_q : scratch_q;
    ctrl_d      = (wr_en && (offset == OFF_CTRL))    ? s1_wdata_q : ctrl_q;
    timestamp_d = timestamp_q + 32'd1;

    // Saturating count of unmapped accesses, reads and writes alike
    err_cnt_d = err_cnt_q;
    if (s1_valid_q && !mapped && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end

    read_val = UNMAP_DATA;
    if (mapped) begin
      case (offset)
        OFF_ID:        read_val = ID_VALUE;
        OFF_SCRATCH:   read_val = scratch_q;
        OFF_CTRL:      read_val = ctrl_q;
        OFF_STATUS:    read_val = status_in;
        OFF_IRQ_STAT:  read_val = {{(DATA_W-IRQ_W){1'b0}}, irq_stat};
        OFF_IRQ_MASK:  read_val = {{(DATA_W-IRQ_W){1'b0}}, irq_mask};
        OFF_TIMESTAMP: read_val = timestamp_q;
        OFF_ERR_CNT:   read_val = err_cnt_q;
        default:       read_val = UNMAP_DATA;
      endcase
    end

    ack_d   = s1_valid_q;
    rdata_d = (s1_valid_q && !s1_write_q) ? read_val : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_write_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_wdata_q  <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      scratch_q   <= '0;
      ctrl_q      <= '0;
      timestamp_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_write_q  <= s1_write_d;
      s1_addr_q   <= s1_addr_d;
      s1_wdata_q  <= s1_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      scratch_q   <= scratch_d;
      ctrl_q      <= ctrl_d;
      timestamp_q <= timestamp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  reg_slave_irq u_irq (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_src  (irq_src),
    .stat_clr (irq_stat_clr),
    .mask_wr  (irq_mask_wr),
    .wdata    (s1_wdata_q[IRQ_W-1:0]),
    .irq_stat (irq_stat),
    .irq_mask (irq_mask),
    .irq      (irq)
  );

  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign ctrl_out  = ctrl_q;

endmodule

// File: tb/tb_reg_slave.sv
// tb_reg_slave
// Directed bench for reg_slave: a vector table for the basic register map
// and pipeline timing, followed by hand-written sequences for timestamp,
// interrupts, reset during traffic and error-counter saturation.
module tb_reg_slave;

  logic        clk;
  logic        rst_n;
  logic        reg_req;
  logic        reg_whrl;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_ack;
  logic [31:0] reg_rdata;
  logic [31:0] ctrl_out;
  logic [31:0] status_in;
  logic [7:0]  irq_src;
  logic        irq;

  int compared;
  int mismatched;

  // One row per cycle: inputs driven that cycle and the outputs expected at
  // the same sample point (the response to the row two cycles earlier).
  typedef struct {
    logic        req;
    logic        whrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] status;
    logic        exp_ack;
    logic [31:0] exp_rdata;
    logic [31:0] exp_ctrl;
  } vec_t;

  localparam int NUM_VECS = 17;
  vec_t vecs[NUM_VECS];

  reg_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_req   (reg_req),
    .reg_whrl  (reg_whrl),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_ack   (reg_ack),
    .reg_rdata (reg_rdata),
    .ctrl_out  (ctrl_out),
    .status_in (status_in),
    .irq_src   (irq_src),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reg_req   = v.req;
    reg_whrl  = v.whrl;
    reg_addr  = v.addr;
    reg_wdata = v.wdata;
    status_in = v.status;
  endtask

  task automatic setVec(input int i, input logic req, input logic whrl,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] status, input logic exp_ack,
                        input logic [31:0] exp_rdata, input logic [31:0] exp_ctrl);
    vecs[i] = '{req, whrl, addr, wdata, status, exp_ack, exp_rdata, exp_ctrl};
  endtask

  task automatic checkVector(input int i);
    checkOutput($sformatf("vec%0d_ack", i), {31'd0, reg_ack}, {31'd0, vecs[i].exp_ack});
    if (vecs[i].exp_ack) begin
      checkOutput($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
    end
    checkOutput($sformatf("vec%0d_ctrl", i), ctrl_out, vecs[i].exp_ctrl);
  endtask

  // Single isolated access: ack must be absent one cycle later and present two
  task automatic access(input string name, input logic whrl, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    reg_req   = 1'b1;
    reg_whrl  = whrl;
    reg_addr  = addr;
    reg_wdata = wdata;
    @(negedge clk);
    reg_req = 1'b0;
    checkOutput({name, "_ack_early"}, {31'd0, reg_ack}, 32'd0);
    @(negedge clk);
    checkOutput({name, "_ack"}, {31'd0, reg_ack}, 32'd1);
    rdata = reg_rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] ts0;
  logic [31:0] ts1;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    reg_req    = 1'b0;
    reg_whrl   = 1'b0;
    reg_addr   = '0;
    reg_wdata  = '0;
    status_in  = '0;
    irq_src    = '0;

    //       i   req whrl addr          wdata         status        ack rdata         ctrl
    setVec(0,  1, 0, 32'h0000_0000, 32'h0,         32'h0,         0, 32'h0,         32'h0);
    setVec(1,  1, 1, 32'h0000_0004, 32'hA5A5_5A5A, 32'h0,         0, 32'h0,         32'h0);
    setVec(2,  1, 0, 32'h0000_0004, 32'h0,         32'h0,         1, 32'h4550_0001, 32'h0);
    setVec(3,  1, 0, 32'h0000_0020, 32'h0,         32'h0,         1, 32'h0,         32'h0);
    setVec(4,  1, 0, 32'h0000_001C, 32'h0,         32'h0,         1, 32'hA5A5_5A5A, 32'h0);
    setVec(5,  1, 1, 32'h0000_0008, 32'h1234_5678, 32'h0,         1, 32'hDEAD_BEEF, 32'h0);
    setVec(6,  1, 0, 32'h0000_0008, 32'h0,         32'h0,         1, 32'h0000_0001, 32'h0);
    setVec(7,  1, 1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,         1, 32'h0,         32'h1234_5678);
    setVec(8,  1, 0, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h1234_5678, 32'h1234_5678);
    setVec(9,  1, 0, 32'h0000_000C, 32'h0,         32'h0,         1, 32'h0,         32'h1234_5678);
    setVec(10, 1, 0, 32'h0000_0002, 32'h0,         32'hCAFE_F00D, 1, 32'h4550_0001, 32'h1234_5678);
    setVec(11, 1, 1, 32'h0000_0040, 32'h55,        32'h0,         1, 32'hCAFE_F00D, 32'h1234_5678);
    setVec(12, 1, 0, 32'h0000_001C, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 32'h1234_5678);
    setVec(13, 1, 0, 32'h1000_0004, 32'h0,         32'h0,         1, 32'h0,         32'h1234_5678);
    setVec(14, 0, 0, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h0000_0003, 32'h1234_5678);
    setVec(15, 0, 0, 32'h0000_0000, 32'h0,         32'h0,         1, 32'hDEAD_BEEF, 32'h1234_5678);
    setVec(16, 0, 0, 32'h0000_0000, 32'h0,         32'h0,         0, 32'h0,         32'h1234_5678);

    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", reg_rdata, 32'h0);
    checkOutput("reset_irq", {31'd0, irq}, 32'd0);

    // Row 0 is checked while still in reset; reset is released on the same
    // edge that presents the first request.
    for (int i = 0; i < NUM_VECS; i++) begin
      if (i > 0) @(negedge clk);
      checkVector(i);
      applyStimulus(vecs[i]);
      if (i == 0) rst_n = 1'b1;
    end

    // Two back-to-back TIMESTAMP reads are one cycle apart
    @(negedge clk);
    reg_req  = 1'b1;
    reg_whrl = 1'b0;
    reg_addr = 32'h18;
    @(negedge clk);
    @(negedge clk);
    reg_req = 1'b0;
    checkOutput("ts_ack0", {31'd0, reg_ack}, 32'd1);
    ts0 = reg_rdata;
    @(negedge clk);
    checkOutput("ts_ack1", {31'd0, reg_ack}, 32'd1);
    ts1 = reg_rdata;
    checkOutput("ts_increment", ts1, ts0 + 32'd1);

    // Interrupt path
    access("mask_wr", 1'b1, 32'h14, 32'h04, rd);
    access("mask_rd", 1'b0, 32'h14, 32'h0, rd);
    checkOutput("mask_rdata", rd, 32'h04);
    checkOutput("irq_idle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    irq_src = 8'h04;
    @(negedge clk);
    irq_src = 8'h00;
    @(negedge clk);
    checkOutput("irq_set", {31'd0, irq}, 32'd1);
    access("stat_rd", 1'b0, 32'h10, 32'h0, rd);
    checkOutput("stat_rdata", rd, 32'h04);

    @(negedge clk);
    irq_src = 8'h04;
    access("clr_held", 1'b1, 32'h10, 32'h04, rd);
    repeat (3) begin
      @(negedge clk);
      checkOutput("irq_set_wins", {31'd0, irq}, 32'd1);
    end
    @(negedge clk);
    irq_src = 8'h00;
    access("clr_stat", 1'b1, 32'h10, 32'h04, rd);
    repeat (2) @(negedge clk);
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
    access("stat_rd2", 1'b0, 32'h10, 32'h0, rd);
    checkOutput("stat_cleared", rd, 32'h0);

    // A masked source latches in IRQ_STAT but does not raise irq
    @(negedge clk);
    irq_src = 8'h01;
    @(negedge clk);
    irq_src = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("irq_masked", {31'd0, irq}, 32'd0);
    access("stat_rd3", 1'b0, 32'h10, 32'h0, rd);
    checkOutput("stat_masked_bit", rd, 32'h01);

    // Reset in the middle of four back-to-back CTRL writes
    @(negedge clk);
    reg_req   = 1'b1;
    reg_whrl  = 1'b1;
    reg_addr  = 32'h08;
    reg_wdata = 32'h1111_1111;
    @(negedge clk);
    rst_n     = 1'b0;
    reg_wdata = 32'h2222_2222;
    checkOutput("rst_ack_a", {31'd0, reg_ack}, 32'd0);
    @(negedge clk);
    reg_wdata = 32'h3333_3333;
    checkOutput("rst_ack_b", {31'd0, reg_ack}, 32'd0);
    @(negedge clk);
    reg_wdata = 32'h4444_4444;
    checkOutput("rst_ack_c", {31'd0, reg_ack}, 32'd0);
    checkOutput("rst_ctrl", ctrl_out, 32'h0);
    @(negedge clk);
    reg_req = 1'b0;
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("post_rst_ack%0d", k), {31'd0, reg_ack}, 32'd0);
      checkOutput($sformatf("post_rst_ctrl%0d", k), ctrl_out, 32'h0);
    end

    // ERR_CNT saturation
    @(negedge clk);
    force dut.err_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.err_cnt_q;
    access("err_rd0", 1'b0, 32'h1C, 32'h0, rd);
    checkOutput("err_forced", rd, 32'hFFFF_FFFF);
    access("err_unmap_wr", 1'b1, 32'h24, 32'h0, rd);
    checkOutput("err_wr_rdata", rd, 32'h0);
    access("err_rd1", 1'b0, 32'h1C, 32'h0, rd);
    checkOutput("err_saturated", rd, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
